// File: rtl/sync_prefetch_fifo_pkg.sv
// Shared helpers for the prefetch FIFO: ceiling log2 and the fill-level width.
package sync_prefetch_fifo_pkg;

  function automatic int clog2(input int value);
    int result;
    int v;
    result = 0;
    v = value - 1;
    while (v > 0) begin
      result++;
      v = v >> 1;
    end
    return result;
  endfunction

  // level counts 0..2**depth_width inclusive, so it needs one extra bit
  function automatic int level_width(input int depth_width);
    return depth_width + 1;
  endfunction

endpackage

// File: rtl/sync_prefetch_fifo_if.sv
// Producer/consumer handshake bundle for sync_prefetch_fifo.
interface sync_prefetch_fifo_if
  import sync_prefetch_fifo_pkg::*;
#(
  parameter int DATA_WIDTH  = 11,
  parameter int DEPTH_WIDTH = 13
);
  localparam int LEVEL_W = level_width(DEPTH_WIDTH);

  logic                  flush;
  logic                  wr_en;
  logic [DATA_WIDTH-1:0] wr_data;
  logic                  wr_vld;
  logic                  rd_en;
  logic [DATA_WIDTH-1:0] rd_data;
  logic                  rd_vld;
  logic [LEVEL_W-1:0]    level;
  logic                  almost_full;
  logic                  almost_empty;
  logic                  overflow;
  logic                  underflow;

  modport master (
    output flush, wr_en, wr_data, rd_en,
    input  wr_vld, rd_data, rd_vld, level, almost_full, almost_empty, overflow, underflow
  );

  modport slave (
    input  flush, wr_en, wr_data, rd_en,
    output wr_vld, rd_data, rd_vld, level, almost_full, almost_empty, overflow, underflow
  );
endinterface

// File: rtl/sync_prefetch_fifo_sdp_ram_reg.sv
// Simple dual-port RAM with registered read; swappable for a vendor block RAM.
module sdp_ram_reg
  import sync_prefetch_fifo_pkg::*;
#(
  parameter int DATA_WIDTH  = 11,
  parameter int DEPTH_WIDTH = 13
) (
  input  logic                   clk,
  input  logic                   wr_en,
  input  logic [DEPTH_WIDTH-1:0] wr_addr,
  input  logic [DATA_WIDTH-1:0]  wr_data,
  input  logic                   rd_en,
  input  logic [DEPTH_WIDTH-1:0] rd_addr,
  output logic [DATA_WIDTH-1:0]  rd_dout
);
  logic [DATA_WIDTH-1:0] mem [2**DEPTH_WIDTH];

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
    if (rd_en) rd_dout <= mem[rd_addr];
  end
endmodule

// File: rtl/sync_prefetch_fifo.sv
// First-word-fall-through FIFO: RAM -> S1 (RAM read register) -> S2 (output register).
module sync_prefetch_fifo
  import sync_prefetch_fifo_pkg::*;
#(
  parameter int DATA_WIDTH  = 11,
  parameter int DEPTH_WIDTH = 13,
  parameter int AF_LEVEL    = (1 << DEPTH_WIDTH) - 4,
  parameter int AE_LEVEL    = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  sync_prefetch_fifo_if.slave bus
);
  localparam int DEPTH   = 1 << DEPTH_WIDTH;
  localparam int LEVEL_W = clog2(DEPTH + 1);

  localparam logic [LEVEL_W-1:0] DEPTH_L = LEVEL_W'(DEPTH);
  localparam logic [LEVEL_W-1:0] AF_L    = LEVEL_W'(AF_LEVEL);
  localparam logic [LEVEL_W-1:0] AE_L    = LEVEL_W'(AE_LEVEL);

  function automatic logic at_or_above(input logic [LEVEL_W-1:0] lvl, input logic [LEVEL_W-1:0] thr);
    return lvl >= thr;
  endfunction

  function automatic logic at_or_below(input logic [LEVEL_W-1:0] lvl, input logic [LEVEL_W-1:0] thr);
    return lvl <= thr;
  endfunction

  logic [DEPTH_WIDTH-1:0] wr_ptr;
  logic [DEPTH_WIDTH-1:0] rd_ptr;
  logic [LEVEL_W-1:0]     level_q;
  logic [LEVEL_W-1:0]     level_nxt;
  logic [LEVEL_W-1:0]     pipe_cnt;
  logic                   s1_vld;
  logic                   s2_vld;
  logic                   wr_vld_q;
  logic                   af_q;
  logic                   ae_q;
  logic                   ovf_q;
  logic                   unf_q;
  logic [DATA_WIDTH-1:0]  rd_data_q;
  logic [DATA_WIDTH-1:0]  ram_dout;
  logic                   wr_fire;
  logic                   pop;
  logic                   s1_load;
  logic                   s2_load;
  logic                   ram_has_data;

  always_comb begin
    wr_fire      = bus.wr_en && wr_vld_q && !bus.flush;
    pop          = bus.rd_en && s2_vld && !bus.flush;
    s2_load      = s1_vld && (!s2_vld || pop);
    // words in RAM = level minus whatever already sits in S1/S2
    pipe_cnt     = LEVEL_W'(s1_vld) + LEVEL_W'(s2_vld);
    ram_has_data = level_q > pipe_cnt;
    s1_load      = ram_has_data && (!s1_vld || s2_load) && !bus.flush;
    level_nxt    = level_q;
    if (wr_fire && !pop) level_nxt = level_q + 1'b1;
    else if (pop && !wr_fire) level_nxt = level_q - 1'b1;
  end

  sdp_ram_reg #(
    .DATA_WIDTH  (DATA_WIDTH),
    .DEPTH_WIDTH (DEPTH_WIDTH)
  ) u_ram (
    .clk     (clk),
    .wr_en   (wr_fire),
    .wr_addr (wr_ptr),
    .wr_data (bus.wr_data),
    .rd_en   (s1_load),
    .rd_addr (rd_ptr),
    .rd_dout (ram_dout)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      level_q   <= '0;
      s1_vld    <= 1'b0;
      s2_vld    <= 1'b0;
      wr_vld_q  <= 1'b0;
      af_q      <= 1'b0;
      ae_q      <= 1'b1;
      ovf_q     <= 1'b0;
      unf_q     <= 1'b0;
      rd_data_q <= '0;
    end else if (bus.flush) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      level_q   <= '0;
      s1_vld    <= 1'b0;
      s2_vld    <= 1'b0;
      wr_vld_q  <= 1'b1;
      af_q      <= at_or_above('0, AF_L);
      ae_q      <= at_or_below('0, AE_L);
      ovf_q     <= 1'b0;
      unf_q     <= 1'b0;
    end else begin
      if (wr_fire) wr_ptr <= wr_ptr + 1'b1;
      if (s1_load) rd_ptr <= rd_ptr + 1'b1;
      level_q  <= level_nxt;
      s1_vld   <= s1_load || (s1_vld && !s2_load);
      s2_vld   <= s2_load || (s2_vld && !pop);
      if (s2_load) rd_data_q <= ram_dout;
      wr_vld_q <= level_nxt < DEPTH_L;
      af_q     <= at_or_above(level_nxt, AF_L);
      ae_q     <= at_or_below(level_nxt, AE_L);
      ovf_q    <= ovf_q || (bus.wr_en && !wr_vld_q);
      unf_q    <= unf_q || (bus.rd_en && !s2_vld);
    end
  end

  assign bus.wr_vld       = wr_vld_q;
  assign bus.rd_data      = rd_data_q;
  assign bus.rd_vld       = s2_vld;
  assign bus.level        = level_q;
  assign bus.almost_full  = af_q;
  assign bus.almost_empty = ae_q;
  assign bus.overflow     = ovf_q;
  assign bus.underflow    = unf_q;
endmodule

// File: tb/tb_sync_prefetch_fifo.sv
// Bench for sync_prefetch_fifo: 64-bit and 1-bit instances, 16 deep, sharing one stimulus stream.
module tb_sync_prefetch_fifo;
  localparam int DEPTH_W = 4;
  localparam int DEPTH   = 16;
  localparam int AF      = 12;
  localparam int AE      = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        flush = 1'b0;
  logic        wr_en = 1'b0;
  logic        rd_en = 1'b0;
  logic [63:0] wr_data = '0;

  always #5 clk = ~clk;

  sync_prefetch_fifo_if #(.DATA_WIDTH(64), .DEPTH_WIDTH(DEPTH_W)) bus_a ();
  sync_prefetch_fifo_if #(.DATA_WIDTH(1),  .DEPTH_WIDTH(DEPTH_W)) bus_b ();

  assign bus_a.flush   = flush;
  assign bus_a.wr_en   = wr_en;
  assign bus_a.wr_data = wr_data;
  assign bus_a.rd_en   = rd_en;
  assign bus_b.flush   = flush;
  assign bus_b.wr_en   = wr_en;
  assign bus_b.wr_data = wr_data[0];
  assign bus_b.rd_en   = rd_en;

  sync_prefetch_fifo #(.DATA_WIDTH(64), .DEPTH_WIDTH(DEPTH_W), .AF_LEVEL(AF), .AE_LEVEL(AE)) dut_a (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_a.slave)
  );

  sync_prefetch_fifo #(.DATA_WIDTH(1), .DEPTH_WIDTH(DEPTH_W), .AF_LEVEL(AF), .AE_LEVEL(AE)) dut_b (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_b.slave)
  );

  // Reference: a queue of words, each tagged with the edge after which it may be shown.
  typedef struct {
    logic [63:0] data;
    int          ready;
  } entry_t;

  entry_t q[$];
  int     cyc;
  logic   m_wr_vld, m_rd_vld, m_ovf, m_unf;
  int     passed, total;

  task automatic chk1(input string name, input logic act, input logic exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %b, required %b (cycle %0d)", name, act, exp, cyc);
  endtask

  task automatic chkw(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got 0x%0h, required 0x%0h (cycle %0d)", name, act, exp, cyc);
  endtask

  task automatic model_reset();
    q.delete();
    m_wr_vld = 1'b0;
    m_rd_vld = 1'b0;
    m_ovf    = 1'b0;
    m_unf    = 1'b0;
  endtask

  task automatic model_edge();
    entry_t h;
    if (flush) begin
      q.delete();
      m_ovf = 1'b0;
      m_unf = 1'b0;
    end else begin
      if (wr_en && !m_wr_vld) m_ovf = 1'b1;
      if (rd_en && !m_rd_vld) m_unf = 1'b1;
      if (rd_en && m_rd_vld) begin
        void'(q.pop_front());
        // the next word cannot be shown before the edge that popped its predecessor
        if (q.size() > 0) begin
          h = q.pop_front();
          if (h.ready < cyc) h.ready = cyc;
          q.push_front(h);
        end
      end
      if (wr_en && m_wr_vld) q.push_back('{data: wr_data, ready: cyc + 2});
    end
    m_wr_vld = q.size() < DEPTH;
    m_rd_vld = (q.size() > 0) && (q[0].ready <= cyc);
  endtask

  task automatic check_model();
    int n;
    n = q.size();
    chk1("a.rd_vld", bus_a.rd_vld, m_rd_vld);
    chk1("b.rd_vld", bus_b.rd_vld, m_rd_vld);
    if (m_rd_vld) begin
      chkw("a.rd_data", bus_a.rd_data, q[0].data);
      chk1("b.rd_data", bus_b.rd_data, q[0].data[0]);
    end
    chkw("a.level", 64'(bus_a.level), 64'(n));
    chkw("b.level", 64'(bus_b.level), 64'(n));
    chk1("a.wr_vld", bus_a.wr_vld, m_wr_vld);
    chk1("a.almost_full", bus_a.almost_full, n >= AF);
    chk1("a.almost_empty", bus_a.almost_empty, n <= AE);
    chk1("a.overflow", bus_a.overflow, m_ovf);
    chk1("a.underflow", bus_a.underflow, m_unf);
    chk1("b.overflow", bus_b.overflow, m_ovf);
    chk1("b.underflow", bus_b.underflow, m_unf);
  endtask

  task automatic step();
    @(posedge clk);
    cyc++;
    model_edge();
    #1;
    check_model();
  endtask

  task automatic do_flush();
    flush = 1'b1;
    step();
    flush = 1'b0;
  endtask

  typedef struct {
    logic        wr_en;
    logic [63:0] data;
    logic        rd_en;
    logic        e_vld;
    logic [63:0] e_data;
    int          e_level;
    logic        e_ae;
  } vec_t;

  vec_t tbl[8];

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int out_cnt;
    logic [63:0] exp_next;

    tbl[0] = '{1'b1, 64'h1, 1'b0, 1'b0, 64'h0, 1, 1'b1};
    tbl[1] = '{1'b1, 64'h2, 1'b0, 1'b0, 64'h0, 2, 1'b1};
    tbl[2] = '{1'b1, 64'h3, 1'b0, 1'b1, 64'h1, 3, 1'b1};
    tbl[3] = '{1'b1, 64'h4, 1'b0, 1'b1, 64'h1, 4, 1'b1};
    tbl[4] = '{1'b1, 64'h5, 1'b0, 1'b1, 64'h1, 5, 1'b0};
    tbl[5] = '{1'b0, 64'h0, 1'b0, 1'b1, 64'h1, 5, 1'b0};
    tbl[6] = '{1'b0, 64'h0, 1'b1, 1'b1, 64'h2, 4, 1'b1};
    tbl[7] = '{1'b0, 64'h0, 1'b1, 1'b1, 64'h3, 3, 1'b1};

    passed = 0;
    total  = 0;
    cyc    = 0;
    model_reset();

    // reset values, then wr_vld rises on the first edge after release
    #12;
    check_model();
    chkw("reset.rd_data", bus_a.rd_data, 64'h0);
    rst_n = 1'b1;
    step();

    for (int i = 0; i < 8; i++) begin
      wr_en   = tbl[i].wr_en;
      wr_data = tbl[i].data;
      rd_en   = tbl[i].rd_en;
      step();
      chk1($sformatf("tbl%0d.rd_vld", i), bus_a.rd_vld, tbl[i].e_vld);
      if (tbl[i].e_vld) chkw($sformatf("tbl%0d.rd_data", i), bus_a.rd_data, tbl[i].e_data);
      chkw($sformatf("tbl%0d.level", i), 64'(bus_a.level), 64'(tbl[i].e_level));
      chk1($sformatf("tbl%0d.almost_empty", i), bus_a.almost_empty, tbl[i].e_ae);
    end
    wr_en = 1'b0;
    rd_en = 1'b0;
    do_flush();

    // fill to capacity, overflow, drain in order, underflow
    for (int i = 0; i < DEPTH; i++) begin
      wr_en   = 1'b1;
      wr_data = 64'h100 + 64'(i);
      step();
    end
    chk1("full.wr_vld", bus_a.wr_vld, 1'b0);
    chkw("full.level", 64'(bus_a.level), 64'd16);
    chk1("full.almost_full", bus_a.almost_full, 1'b1);
    wr_data = 64'h1FF;
    step();
    wr_en = 1'b0;
    chk1("full.overflow", bus_a.overflow, 1'b1);
    chkw("full.level_after_drop", 64'(bus_a.level), 64'd16);
    for (int i = 0; i < DEPTH; i++) begin
      chkw($sformatf("drain%0d.rd_data", i), bus_a.rd_data, 64'h100 + 64'(i));
      rd_en = 1'b1;
      step();
    end
    rd_en = 1'b0;
    chk1("drain.rd_vld_empty", bus_a.rd_vld, 1'b0);
    rd_en = 1'b1;
    step();
    rd_en = 1'b0;
    chk1("drain.underflow", bus_a.underflow, 1'b1);

    // simultaneous write and pop while full
    do_flush();
    for (int i = 0; i < DEPTH; i++) begin
      wr_en   = 1'b1;
      wr_data = 64'h300 + 64'(i);
      step();
    end
    rd_en = 1'b1;
    step();
    wr_en = 1'b0;
    rd_en = 1'b0;
    chkw("fullrw.level", 64'(bus_a.level), 64'd15);
    chk1("fullrw.overflow", bus_a.overflow, 1'b1);
    chkw("fullrw.rd_data", bus_a.rd_data, 64'h301);
    do_flush();

    // streaming across three pointer wraps
    exp_next = 64'h0;
    out_cnt  = 0;
    for (int i = 0; i < 3 * DEPTH; i++) begin
      wr_en   = 1'b1;
      rd_en   = 1'b1;
      wr_data = 64'(i);
      step();
      if (bus_a.rd_vld) begin
        chkw("stream.rd_data", bus_a.rd_data, exp_next);
        exp_next++;
        out_cnt++;
      end
      if (i >= 2) chkw("stream.level", 64'(bus_a.level), 64'd3);
    end
    wr_en = 1'b0;
    rd_en = 1'b0;
    chkw("stream.words_out", 64'(out_cnt), 64'd46);
    do_flush();

    // flush at level 8 with both error flags set and write/pop requested
    rd_en = 1'b1;
    step();
    rd_en = 1'b0;
    for (int i = 0; i <= DEPTH; i++) begin
      wr_en   = 1'b1;
      wr_data = 64'h200 + 64'(i);
      step();
    end
    wr_en = 1'b0;
    for (int i = 0; i < 8; i++) begin
      rd_en = 1'b1;
      step();
    end
    chkw("flush.pre_level", 64'(bus_a.level), 64'd8);
    flush   = 1'b1;
    wr_en   = 1'b1;
    rd_en   = 1'b1;
    wr_data = 64'hDEAD;
    step();
    flush = 1'b0;
    wr_en = 1'b0;
    rd_en = 1'b0;
    chkw("flush.level", 64'(bus_a.level), 64'd0);
    chk1("flush.rd_vld", bus_a.rd_vld, 1'b0);
    chk1("flush.wr_vld", bus_a.wr_vld, 1'b1);
    chk1("flush.almost_empty", bus_a.almost_empty, 1'b1);
    chk1("flush.almost_full", bus_a.almost_full, 1'b0);
    chk1("flush.overflow", bus_a.overflow, 1'b0);
    chk1("flush.underflow", bus_a.underflow, 1'b0);
    repeat (3) step();
    chk1("flush.word_gone", bus_a.rd_vld, 1'b0);
    wr_en   = 1'b1;
    wr_data = 64'hAA;
    step();
    wr_en = 1'b0;
    repeat (2) step();
    chkw("flush.new_word", bus_a.rd_data, 64'hAA);
    do_flush();

    // asynchronous reset mid-burst at level 6
    for (int i = 0; i < 6; i++) begin
      wr_en   = 1'b1;
      wr_data = 64'h400 + 64'(i);
      step();
    end
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    check_model();
    chkw("areset.rd_data", bus_a.rd_data, 64'h0);
    wr_en = 1'b0;
    @(posedge clk);
    #3;
    rst_n = 1'b1;
    #1;
    check_model();
    step();
    chk1("areset.wr_vld_up", bus_a.wr_vld, 1'b1);

    // randomised traffic against the reference
    for (int seg = 0; seg < 10; seg++) begin
      int pw, pr;
      pw = int'($urandom_range(10, 90));
      pr = int'($urandom_range(10, 90));
      for (int i = 0; i < 250; i++) begin
        flush   = ($urandom_range(0, 99) == 0);
        wr_en   = ($urandom_range(0, 99) < pw);
        rd_en   = ($urandom_range(0, 99) < pr);
        wr_data = {$urandom, $urandom};
        step();
      end
    end
    flush = 1'b0;
    wr_en = 1'b0;
    rd_en = 1'b0;

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/sync_prefetch_fifo.md
# sync_prefetch_fifo

Parametrised single-clock prefetch (first-word-fall-through) FIFO. Successor to the fixed-size prefetch FIFO wrappers used across the acquisition datapath. Adds parametric width and depth, a live fill level, programmable almost-full/almost-empty flags, synchronous flush, and sticky overflow/underflow error flags. Sits between sample producers (ADC capture, decimators) and consumers (FFT/display engines) within one clock domain.

## Interface
- DATA_WIDTH, 11, word width in bits (1–1152)
- DEPTH_WIDTH, 13, log2 of capacity; DEPTH = 2**DEPTH_WIDTH words (legal 4–20)
- AF_LEVEL, DEPTH-4, almost_full asserts when level >= AF_LEVEL (1..DEPTH)
- AE_LEVEL, 4, almost_empty asserts when level <= AE_LEVEL (0..DEPTH-1)
- clk  input  1  single clock, all logic rising-edge
- rst_n  input  1  reset, asynchronous assert, active-low
- flush  input  1  synchronous clear of all contents and error flags
- wr_en  input  1  write request
- wr_data  input  DATA_WIDTH  write data
- wr_vld  output  1  space available; a write is accepted on a cycle with wr_en && wr_vld
- rd_en  input  1  read/pop request
- rd_data  output  DATA_WIDTH  head word, valid while rd_vld
- rd_vld  output  1  rd_data holds the head word; pop on rd_en && rd_vld
- level  output  DEPTH_WIDTH+1  words accepted and not yet popped (0..DEPTH)
- almost_full  output  1  level >= AF_LEVEL
- almost_empty  output  1  level <= AE_LEVEL
- overflow  output  1  sticky: wr_en seen while wr_vld low
- underflow  output  1  sticky: rd_en seen while rd_vld low

## Operation
- Storage: simple dual-port RAM, DEPTH x DATA_WIDTH, registered read with read enable (stage S1), followed by output register S2 driving rd_data/rd_vld.
- Capacity DEPTH counts RAM, S1 and S2 together; wr_vld = (level < DEPTH), registered.
- Pointers wr_ptr/rd_ptr are DEPTH_WIDTH bits and wrap modulo DEPTH naturally; full/empty are derived from level, not pointer comparison.
- Prefetch control: S2 loads from S1 when S2 is empty or popping and S1 is valid. S1 loads from the RAM when RAM is non-empty and S1 is empty or moving into S2. S1 and S2 hold otherwise. No bubbles while data is available.
- level: +1 on an accepted write, -1 on a pop, unchanged when both occur. Flags are computed from the next-level value and registered, so they track level in the same cycle.
- Write with wr_vld low: dropped, overflow set. Read with rd_vld low: ignored, underflow set. The flags remain set until flush or reset.
- flush takes priority over a same-cycle write or pop (both ignored). Next cycle: level 0, rd_vld 0, wr_vld 1, almost_empty 1, almost_full 0, overflow/underflow 0. RAM contents are not cleared.
- Reset values (rst_n low, asynchronous): rd_vld 0, rd_data 0, wr_vld 0, level 0, almost_full 0, almost_empty 1, overflow 0, underflow 0, pointers 0. wr_vld rises on the first clk edge after rst_n deasserts. Reset mid-burst discards all contents.

## Timing
- Write-to-read latency into an empty FIFO: write accepted at edge k; rd_vld=1 with that word after edge k+2.
- Steady state: one write and one pop per cycle sustained indefinitely; rd_data advances every cycle while rd_en && rd_vld.
- Pop at edge k: the next word is on rd_data after edge k if S1 was valid; otherwise rd_vld drops.
- wr_vld, level and flags update on the edge that accepts a write or pop. At level DEPTH-1 with a write and no pop, wr_vld is 0 the next cycle.
- Simultaneous write and pop at full: the pop is honoured; the write is refused (wr_vld was 0) and overflow sets.

## Structure
- Shared package: the function clog2, and a level-width constant derived from DEPTH_WIDTH. Flag comparison helpers are kept local.
- One sub-module: sdp_ram_reg (parametrised DATA_WIDTH/DEPTH_WIDTH, write port, read port with read enable and a registered dout). This keeps it replaceable by a vendor DRM primitive.
- Top level holds pointers, level counter, S1/S2 valid control, flags, and error flags. Target size is about 200 lines.

## Test plan
- After reset, write 0x001..0x005 back-to-back with rd_en=0 → rd_vld rises 2 cycles after the first write, rd_data=0x001, level=5, almost_empty=0 (AE_LEVEL=4).
- DEPTH_WIDTH=4: write 16 words → wr_vld=0, level=16, almost_full=1. A 17th write is dropped and overflow=1. Drain all → order preserved, the last pop gives rd_vld=0, and an extra rd_en sets underflow=1.
- Continuous write with rd_en=1 for 3*DEPTH cycles → one word out per cycle, incrementing pattern intact across pointer wrap, level constant.
- At level 8, assert flush with wr_en and rd_en high → next cycle level=0, rd_vld=0, wr_vld=1, overflow/underflow cleared. The written word is not present.
- Drop rst_n asynchronously mid-burst at level 6 → outputs take reset values immediately; wr_vld=1 after the first edge post-release.
- Randomised wr_en/rd_en against a scoreboard model, DATA_WIDTH=1 and 64 → data order and level match every cycle.
